selevy_gout_rx: RTL and testbench
=================================

# selevy_gout_rx

Receiving end of the selevy CPU's general-purpose output port. Samples `gout[3:0]` on each rising edge of the CPU-generated strobe `out_clk` and pairs consecutive nibbles (low first) into bytes. Buffers the bytes in a small first-word-fall-through FIFO, which a host or bench drains with a valid/ready handshake. Sits beside `selevy` in the top level and replaces ad-hoc waveform inspection of `gout` with a checkable byte stream.

## Interface
Parameters:
- `FIFO_DEPTH`, 8, byte entries; power of two, minimum 2.
- `TIMEOUT`, 255, idle `CLK` cycles allowed between low and high nibble (only with `SELEVY_RX_TIMEOUT_EN`).

Ports:
- `CLK`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `gout`  in  4  nibble from CPU; stable while `out_clk` is high.
- `out_clk`  in  1  CPU output strobe, asynchronous to `CLK`.
- `rd_data`  out  8  FIFO head byte; valid when `rd_valid` = 1.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  host accepts head byte.
- `count`  out  log2(FIFO_DEPTH)+1  bytes currently stored.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Synchroniser: `out_clk` and `gout` pass through two flops each (s1, s2). A third flop s3 holds the previous s2 value of `out_clk`. `strobe` = s2 & ~s3.
- Nibble FSM, two states:
  - LO: on `strobe`, latch s2 `gout` into `lo_nib` and go to HI.
  - HI: on `strobe`, push byte {s2 `gout`, `lo_nib`} and go to LO.
- FIFO is first-word-fall-through:
  - `rd_data` = head entry; `rd_valid` = (`count` != 0).
  - Pop when `rd_valid` & `rd_ready`.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `count` increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- Full and push:
  - Without a pop in the same cycle: the byte is dropped, `overflow` is set, FIFO contents are unchanged, and the FSM still returns to LO.
  - With a pop in the same cycle: the push is accepted and `overflow` is not set.
- Empty: `rd_ready` is ignored, with no underflow and no pointer movement.
- `clr_ovf` together with a new overflow event: set wins, so `overflow` stays 1.
- Reset, asserted at any time including mid-byte: FSM goes to LO, `lo_nib` is discarded, pointers and `count` go to 0, and all sync flops go to 0.
- Reset values: `rd_valid`=0, `rd_data`=8'h00, `count`=0, `overflow`=0.

## Timing
- `out_clk` high and low phases must each be ≥ 2 `CLK` periods; shorter pulses may be missed. This is a bench requirement, not checked.
- Define edge k as the first `CLK` edge that samples `out_clk`=1 into s1.
  - s2 = 1 after edge k+1.
  - `strobe` is high for exactly one cycle, between edges k+1 and k+2.
- For a high nibble, the push happens at edge k+2, and `rd_valid`/`count` reflect it after edge k+2. This is 2-cycle latency from s1 capture.
- Pop takes effect at the edge where `rd_valid` & `rd_ready`. The next head byte appears on `rd_data` after that edge, so back-to-back pops deliver one byte per cycle.
- `overflow` rises after the edge of the dropped push. `clr_ovf` clears it at the next edge.

## Configuration
- `SELEVY_RX_TIMEOUT_EN` defined:
  - A counter runs while in HI and resets on entry to HI.
  - If `TIMEOUT` cycles elapse without a `strobe`, the FSM returns to LO and `lo_nib` is discarded. Nothing is pushed and `overflow` is not touched.
  - A `strobe` arriving in the same cycle the counter expires wins, and the byte is pushed.
- Undefined: no counter is built, HI waits indefinitely, and `TIMEOUT` is ignored.

## Test plan
- Single byte: nibbles 4'h5 then 4'hA on `out_clk` pulses (3 cycles high, 3 low) -> `rd_valid` rises 2 cycles after the second s1 capture, with `rd_data`=8'hA5 and `count`=1. `rd_ready`=1 for one cycle -> `rd_valid`=0, `count`=0.
- Burst: bytes 8'h01..8'h08 with `rd_ready`=0 -> `count`=8, `overflow`=0. A 9th byte 8'hFF -> `overflow`=1, `count`=8. Drain -> 01..08 in order, no FF.
- Full with simultaneous pop: FIFO full and `rd_ready`=1 in the push cycle -> `count` stays 8, `overflow`=0, and the new byte is last out.
- Reset mid-byte: low nibble 4'h3 captured, then `reset`=0 for 1 cycle, then nibbles 4'h7, 4'h2 -> output byte 8'h27. All outputs read 0 during reset.
- Timeout (macro on, `TIMEOUT`=10): nibble 4'hC, idle 20 cycles, then nibbles 4'h1, 4'h2 -> single byte 8'h21. With the macro off, the same stimulus gives 8'h1C, and 4'h2 stays pending in `lo_nib`.
- `clr_ovf`: after overflow, pulse `clr_ovf` -> `overflow`=0 next cycle. Pulsing `clr_ovf` in the same cycle as a drop -> `overflow` stays 1.

Source files
------------

// File: rtl/selevy_gout_rx.sv
// selevy gout receiver: syncs out_clk/gout, pairs nibbles into bytes, FWFT FIFO.
// Optional HI-state idle timeout when SELEVY_RX_TIMEOUT_EN is defined.
module selevy_gout_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [3:0]                  gout,
  input  logic                        out_clk,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  input  logic                        clr_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {LO, HI} state_t;

  logic       oc_s1, oc_s2, oc_s3;
  logic [3:0] g_s1, g_s2;
  logic       strobe;

  state_t     state_q, state_d;
  logic [3:0] lo_nib;
  logic       push;
  logic       tmo_exp;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          full, pop, wr_en, drop;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      oc_s1 <= 1'b0;
      oc_s2 <= 1'b0;
      oc_s3 <= 1'b0;
      g_s1  <= '0;
      g_s2  <= '0;
    end else begin
      oc_s1 <= out_clk;
      oc_s2 <= oc_s1;
      oc_s3 <= oc_s2;
      g_s1  <= gout;
      g_s2  <= g_s1;
    end
  end

  assign strobe = oc_s2 & ~oc_s3;

`ifdef SELEVY_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q;

  // Held at zero outside HI, so it restarts on every HI entry
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      tmo_q <= '0;
    else if (state_q != HI)
      tmo_q <= '0;
    else
      tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_exp = (state_q == HI) && (tmo_q == TW'(TIMEOUT - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
  assign tmo_exp    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      state_q <= LO;
    else
      state_q <= state_d;
  end

  // A strobe in the expiry cycle wins over the timeout
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      LO: if (strobe) state_d = HI;
      HI: begin
        if (strobe) begin
          push    = 1'b1;
          state_d = LO;
        end else if (tmo_exp) begin
          state_d = LO;
        end
      end
      default: state_d = LO;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      lo_nib <= '0;
    else if (state_q == LO && strobe)
      lo_nib <= g_s2;
  end

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = rd_valid & rd_ready;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[wr_ptr] <= {g_s2, lo_nib};
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (clr_ovf)
      overflow <= 1'b0;
  end

  assign rd_valid = (cnt_q != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;
  assign count    = cnt_q;

endmodule

// File: tb/tb_selevy_gout_rx.sv
// Randomised bench for selevy_gout_rx against a queue-based byte-stream model.
// Timeout expectations follow SELEVY_RX_TIMEOUT_EN, with TIMEOUT set to 10.
module tb_selevy_gout_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 10;

  logic       CLK = 1'b0;
  logic       reset;
  logic [3:0] gout;
  logic       out_clk;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] count;
  logic       overflow;
  logic       clr_ovf;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mq [$];
  logic [3:0] m_lo;
  bit         m_have;
  bit         m_ovf;

  selevy_gout_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .gout     (gout),
    .out_clk  (out_clk),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Byte-stream model: nibble pairing plus bounded FIFO with drop-on-full
  function automatic void m_nib(input logic [3:0] n);
    if (!m_have) begin
      m_lo   = n;
      m_have = 1'b1;
    end else begin
      m_have = 1'b0;
      if (mq.size() < DEPTH) mq.push_back({n, m_lo});
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic send_nib(input logic [3:0] n);
    gout    = n;
    out_clk = 1'b1;
    tick(3);
    out_clk = 1'b0;
    tick(3);
    m_nib(n);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[3:0]);
    send_nib(b[7:4]);
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] e;
    e = mq[0];
    chk({tag, "_v"}, rd_valid, 1);
    chk({tag, "_d"}, rd_data, e);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    void'(mq.pop_front());
    chk({tag, "_c"}, count, mq.size());
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) pop_one(tag);
    chk({tag, "_empty"}, rd_valid, 0);
  endtask

  task automatic clr_pulse();
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    m_ovf   = 1'b0;
  endtask

  initial begin
    logic [3:0] h;
    logic [7:0] tb_exp;
    int         r;

    reset    = 1'b0;
    out_clk  = 1'b0;
    gout     = '0;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    m_have   = 1'b0;
    m_ovf    = 1'b0;
    m_lo     = '0;

    tick(2);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b1;
    tick(1);

    // single byte with latency from s1 capture
    send_nib(4'h5);
    gout    = 4'hA;
    out_clk = 1'b1;
    tick(1);
    chk("lat_k", rd_valid, 0);
    tick(1);
    chk("lat_k1", rd_valid, 0);
    tick(1);
    chk("lat_k2_v", rd_valid, 1);
    chk("lat_k2_d", rd_data, 8'hA5);
    chk("lat_k2_c", count, 1);
    out_clk = 1'b0;
    tick(3);
    m_nib(4'hA);
    pop_one("single");

    // burst to full, then drop
    for (int b = 1; b <= 8; b++) send_byte(8'(b));
    chk("burst_cnt", count, 8);
    chk("burst_ovf", overflow, 0);
    send_byte(8'hFF);
    chk("drop_ovf", overflow, 1);
    chk("drop_cnt", count, 8);
    clr_pulse();
    chk("clr_ovf", overflow, 0);
    for (int b = 1; b <= 8; b++) begin
      chk("burst_order", rd_data, 32'(b));
      pop_one("burst");
    end
    chk("burst_empty", rd_valid, 0);

    // full with simultaneous pop
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom));
    send_nib(4'($urandom));
    h       = 4'($urandom);
    gout    = h;
    out_clk = 1'b1;
    tick(2);
    chk("fp_head", rd_data, mq[0]);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    chk("fp_cnt", count, 8);
    chk("fp_ovf", overflow, 0);
    void'(mq.pop_front());
    out_clk = 1'b0;
    tick(3);
    m_nib(h);
    tb_exp = {h, m_lo};
    chk("fp_last", mq[DEPTH-1], tb_exp);
    drain("fp");

    // drop coinciding with clr_ovf: set wins
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom));
    send_nib(4'($urandom));
    h       = 4'($urandom);
    gout    = h;
    out_clk = 1'b1;
    tick(2);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    m_nib(h);
    chk("setwins_ovf", overflow, 1);
    out_clk = 1'b0;
    tick(3);
    clr_pulse();
    chk("clr2_ovf", overflow, 0);
    drain("sw");

    // reset mid-byte
    send_byte(8'h5C);
    send_nib(4'h3);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_data", rd_data, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ovf", overflow, 0);
    tick(1);
    reset = 1'b1;
    mq.delete();
    m_have = 1'b0;
    m_ovf  = 1'b0;
    tick(1);
    send_nib(4'h7);
    send_nib(4'h2);
    chk("mid_rst_byte", rd_data, 8'h27);
    pop_one("midrst");

    // HI-state idle timeout
    send_nib(4'hC);
    tick(20);
`ifdef SELEVY_RX_TIMEOUT_EN
    m_have = 1'b0;
    tb_exp = 8'h21;
`else
    tb_exp = 8'h1C;
`endif
    send_nib(4'h1);
    send_nib(4'h2);
    chk("tmo_byte", rd_data, tb_exp);
    pop_one("tmo");
    chk("tmo_cnt", count, 0);

    // randomised mix
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        send_byte(8'($urandom));
      end else if (r <= 7) begin
        if (mq.size() > 0) begin
          pop_one("rnd");
        end else begin
          rd_ready = 1'b1;
          tick(1);
          rd_ready = 1'b0;
          chk("rnd_empty_v", rd_valid, 0);
          chk("rnd_empty_c", count, 0);
        end
      end else if (r == 8) begin
        clr_pulse();
      end else begin
        tick($urandom_range(1, 3));
      end
      chk("rnd_cnt", count, mq.size());
      chk("rnd_ovf", overflow, m_ovf);
    end
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
